ffsr_spike_fire: RTL and testbench

- Downstream consumer of the ffsr_spike thermometer register.
- Samples the INPUT_SIZE-bit thermometer vector and converts it to a binary level (popcount).
- Compares the level against a programmable threshold inside a gamma window.
- Emits one first-crossing spike per gamma cycle with its spike time; this is the temporal-coded output used by the next column/WTA stage.

---
 rtl/ffsr_spike_fire.sv | 104 ++++++++++
 tb/tb_ffsr_spike_fire.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ffsr_spike_fire.sv
// Thermometer-to-level converter with a first-crossing spike per gamma window.
// Optional FFSR_FIRE_CLR_EN adds ffsr_inc/ffsr_dec pulses that clear the upstream ffsr_spike on fire.
module ffsr_spike_fire #(
    parameter  int INPUT_SIZE = 16,
    parameter  int GAMMA_LEN  = 16,
    localparam int LW         = $clog2(INPUT_SIZE + 1),
    localparam int TW         = $clog2(GAMMA_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gamma_start,
    input  logic [0:INPUT_SIZE-1] therm_in,
    input  logic [LW-1:0]         threshold,
    output logic [LW-1:0]         level,
    output logic                  spike,
    output logic                  spike_valid,
    output logic [TW-1:0]         spike_time,
    output logic                  done,
`ifdef FFSR_FIRE_CLR_EN
    output logic                  ffsr_inc,
    output logic                  ffsr_dec,
`endif
    output logic                  therm_err
);

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_HOLD} state_t;

    state_t                  state;
    logic [0:INPUT_SIZE-1]   therm_q;
    logic [INPUT_SIZE-1:0]   therm_v;
    logic [LW-1:0]           thr_q;
    logic [TW-1:0]           t_cnt;
    logic                    therm_legal;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        level = '0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            level = level + LW'(therm_q[i]);
        end
    end

    // Index INPUT_SIZE-1 is the LSB, so a legal code is numerically 2^k-1.
    assign therm_v     = therm_q;
    assign therm_legal = ((therm_v & (therm_v + INPUT_SIZE'(1))) == '0);
    assign done        = (state == S_HOLD);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WAIT;
            therm_q     <= '0;
            thr_q       <= '0;
            t_cnt       <= '0;
            spike       <= 1'b0;
            spike_valid <= 1'b0;
            spike_time  <= TW'(GAMMA_LEN);
            therm_err   <= 1'b0;
`ifdef FFSR_FIRE_CLR_EN
            ffsr_inc    <= 1'b0;
            ffsr_dec    <= 1'b0;
`endif
        end else begin
            therm_q <= therm_in;
            spike   <= 1'b0;
`ifdef FFSR_FIRE_CLR_EN
            ffsr_inc <= 1'b0;
            ffsr_dec <= 1'b0;
`endif
            if (gamma_start) begin
                // A new window wins over any fire condition on the same edge.
                thr_q       <= threshold;
                t_cnt       <= '0;
                spike_valid <= 1'b0;
                spike_time  <= TW'(GAMMA_LEN);
                therm_err   <= 1'b0;
                state       <= S_RUN;
            end else begin
                case (state)
                    S_RUN: begin
                        if (!therm_legal) therm_err <= 1'b1;
                        if (level >= thr_q) begin
                            spike       <= 1'b1;
                            spike_valid <= 1'b1;
                            spike_time  <= t_cnt;
                            state       <= S_HOLD;
`ifdef FFSR_FIRE_CLR_EN
                            ffsr_inc    <= 1'b1;
                            ffsr_dec    <= 1'b1;
`endif
                        end else if (t_cnt == TW'(GAMMA_LEN - 1)) begin
                            spike_time <= TW'(GAMMA_LEN);
                            state      <= S_HOLD;
                        end else begin
                            t_cnt <= t_cnt + TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ffsr_spike_fire.sv
// Self-checking bench for ffsr_spike_fire: vector table, hand-written corner sequences,
// and randomized stimulus against a window-level reference model.
module tb_ffsr_spike_fire;

    localparam int N  = 16;
    localparam int G  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        gamma_start;
    logic [0:N-1] therm_in;
    logic [4:0]  threshold;
    logic [4:0]  level;
    logic        spike;
    logic        spike_valid;
    logic [4:0]  spike_time;
    logic        done;
    logic        therm_err;
`ifdef FFSR_FIRE_CLR_EN
    logic        ffsr_inc;
    logic        ffsr_dec;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ffsr_spike_fire #(.INPUT_SIZE(N), .GAMMA_LEN(G)) dut (
        .clk(clk),
        .rst(rst),
        .gamma_start(gamma_start),
        .therm_in(therm_in),
        .threshold(threshold),
        .level(level),
        .spike(spike),
        .spike_valid(spike_valid),
        .spike_time(spike_time),
        .done(done),
`ifdef FFSR_FIRE_CLR_EN
        .ffsr_inc(ffsr_inc),
        .ffsr_dec(ffsr_dec),
`endif
        .therm_err(therm_err)
    );

    // Reference model: tracks the window by absolute cycle numbers.
    int          cyc = 0;
    int          m_mode = 0;          // 0 idle, 1 window open, 2 resolved
    int          m_open_cyc = 0;
    int          m_thr = 0;
    logic [15:0] m_prev = '0;
    bit          m_spike = 0, m_sv = 0, m_err = 0;
    int          m_st = G;

    function automatic bit is_therm(input logic [15:0] v);
        int ones = $countones(v);
        return (v == 16'((32'h1 << ones) - 1));
    endfunction

    task automatic model(input logic r, input logic g, input logic [15:0] t, input logic [4:0] th);
        int elapsed;
        cyc++;
        if (r) begin
            m_mode = 0; m_thr = 0; m_prev = '0; m_spike = 0; m_sv = 0; m_err = 0; m_st = G;
            return;
        end
        m_spike = 0;
        if (g) begin
            m_mode = 1; m_open_cyc = cyc; m_thr = th; m_sv = 0; m_err = 0; m_st = G;
        end else if (m_mode == 1) begin
            elapsed = cyc - m_open_cyc - 1;
            if (!is_therm(m_prev)) m_err = 1;
            if ($countones(m_prev) >= m_thr) begin
                m_spike = 1; m_sv = 1; m_st = elapsed; m_mode = 2;
            end else if (elapsed == G - 1) begin
                m_st = G; m_mode = 2;
            end
        end
        m_prev = t;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic g, input logic [15:0] t, input logic [4:0] th);
        rst = r; gamma_start = g; therm_in = t; threshold = th;
        @(posedge clk);
        model(r, g, t, th);
        @(negedge clk);
    endtask

    task automatic check_model();
        check("level",       32'(level),       32'($countones(m_prev)));
        check("spike",       32'(spike),       32'(m_spike));
        check("spike_valid", 32'(spike_valid), 32'(m_sv));
        check("spike_time",  32'(spike_time),  32'(m_st));
        check("done",        32'(done),        32'(m_mode == 2));
        check("therm_err",   32'(therm_err),   32'(m_err));
`ifdef FFSR_FIRE_CLR_EN
        check("ffsr_inc",    32'(ffsr_inc),    32'(m_spike));
        check("ffsr_dec",    32'(ffsr_dec),    32'(m_spike));
`endif
    endtask

    typedef struct {
        logic        r, g;
        logic [15:0] t;
        logic [4:0]  th;
        int          lvl, spk, sv, st, dn, err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int lvl;
        logic [15:0] tv;
        rst = 1'b1; gamma_start = 1'b0; therm_in = '0; threshold = '0;
        @(negedge clk);

        //            r  g  therm      th  lvl spk sv st  dn err
        vecs[0]  = '{1, 0, 16'hFFFF,  0,  0,  0,  0, 16, 0, 0};
        vecs[1]  = '{1, 0, 16'hFFFF,  0,  0,  0,  0, 16, 0, 0};
        vecs[2]  = '{1, 0, 16'hFFFF,  0,  0,  0,  0, 16, 0, 0};
        vecs[3]  = '{0, 1, 16'h000F,  7,  4,  0,  0, 16, 0, 0};
        vecs[4]  = '{0, 0, 16'h001F,  7,  5,  0,  0, 16, 0, 0};
        vecs[5]  = '{0, 0, 16'h003F,  7,  6,  0,  0, 16, 0, 0};
        vecs[6]  = '{0, 0, 16'h007F,  7,  7,  0,  0, 16, 0, 0};
        vecs[7]  = '{0, 0, 16'h00FF,  7,  8,  1,  1,  3, 1, 0};
        vecs[8]  = '{0, 0, 16'h00FF,  7,  8,  0,  1,  3, 1, 0};
        vecs[9]  = '{0, 0, 16'h00FF,  7,  8,  0,  1,  3, 1, 0};
        vecs[10] = '{0, 1, 16'h0101, 20,  2,  0,  0, 16, 0, 0};
        vecs[11] = '{0, 0, 16'h0101, 20,  2,  0,  0, 16, 0, 1};
        vecs[12] = '{0, 1, 16'h0000, 20,  0,  0,  0, 16, 0, 0};

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].g, vecs[i].t, vecs[i].th);
            check($sformatf("vec%0d.level", i),       32'(level),       32'(vecs[i].lvl));
            check($sformatf("vec%0d.spike", i),       32'(spike),       32'(vecs[i].spk));
            check($sformatf("vec%0d.spike_valid", i), 32'(spike_valid), 32'(vecs[i].sv));
            check($sformatf("vec%0d.spike_time", i),  32'(spike_time),  32'(vecs[i].st));
            check($sformatf("vec%0d.done", i),        32'(done),        32'(vecs[i].dn));
            check($sformatf("vec%0d.therm_err", i),   32'(therm_err),   32'(vecs[i].err));
        end

        // Timeout: level 5 never reaches 12, window resolves after 16 RUN edges.
        step(0, 1, 16'h001F, 12);
        for (int i = 0; i < G; i++) begin
            step(0, 0, 16'h001F, 12);
            check("timeout.spike", 32'(spike), 0);
            check("timeout.done",  32'(done),  32'(i == G - 1));
        end
        check("timeout.spike_valid", 32'(spike_valid), 0);
        check("timeout.spike_time",  32'(spike_time),  16);

        // Collision: gamma_start on the crossing edge suppresses the spike and restarts t_cnt.
        step(0, 1, 16'h000F, 3);
        step(0, 1, 16'h000F, 3);
        check("collide.spike",       32'(spike),       0);
        check("collide.spike_valid", 32'(spike_valid), 0);
        check("collide.spike_time",  32'(spike_time),  16);
        check("collide.done",        32'(done),        0);
        step(0, 0, 16'h000F, 3);
        check("collide.refire",      32'(spike),       1);
        check("collide.refire_time", 32'(spike_time),  0);

        // Reset mid-window abandons it; idle state ignores illegal codes and never resolves.
        step(0, 1, 16'h0003, 20);
        repeat (3) step(0, 0, 16'h0101, 20);
        check("midrun.err_before", 32'(therm_err), 1);
        step(1, 0, 16'hFFFF, 20);
        check("midrun.level",       32'(level),       0);
        check("midrun.spike_valid", 32'(spike_valid), 0);
        check("midrun.spike_time",  32'(spike_time),  16);
        check("midrun.done",        32'(done),        0);
        check("midrun.therm_err",   32'(therm_err),   0);
        repeat (20) step(0, 0, 16'h0101, 0);
        check("idle.done",      32'(done),      0);
        check("idle.therm_err", 32'(therm_err), 0);
        check("idle.spike",     32'(spike),     0);

        // Randomized run against the reference model.
        lvl = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r, g;
            r = ($urandom_range(0, 199) == 0);
            g = ($urandom_range(0, 23) == 0);
            if (g) lvl = $urandom_range(0, 4);
            else if ($urandom_range(0, 2) != 0 && lvl < N) lvl++;
            tv = 16'((32'h1 << lvl) - 1);
            if ($urandom_range(0, 15) == 0) tv = 16'($urandom);
            step(r, g, tv, 5'($urandom_range(0, 20)));
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
